// File: rtl/victim_fill_ctrl_lv1.sv
`default_nettype none
// ============================================================================
// Module   : victim_fill_ctrl_lv1
// Purpose  : L1 miss-handling controller. It takes the pseudo-LRU victim way
//            for the missing set. If that victim is Modified it is written
//            back first. The missing block is then fetched from the lower
//            level and installed into the tag/data arrays. Only one miss is
//            outstanding at a time.
// Ports    : clk/rst_n           - clock, asynchronous active-low reset
//            miss_*              - miss strobe and address from hit/miss logic
//            lru_replacement_proc, victim_* - victim way and its state/tag/data
//            wb_*                - writeback request/payload and acknowledge
//            fill_*              - fill request/address, returned data/ack
//            arr_wr_*            - one-cycle array write of the new block
//            busy / fill_done    - miss in progress / completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module victim_fill_ctrl_lv1 #(
    parameter int ASSOC_WID = 2,
    parameter int INDEX_MSB = 9,
    parameter int INDEX_LSB = 4,
    parameter int TAG_WID   = 22,
    parameter int BLK_WID   = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miss_req,
    input  logic                         miss_excl,
    input  logic [INDEX_MSB-INDEX_LSB:0] miss_index,
    input  logic [TAG_WID-1:0]           miss_tag,
    input  logic [ASSOC_WID-1:0]         lru_replacement_proc,
    input  logic [1:0]                   victim_state,
    input  logic [TAG_WID-1:0]           victim_tag,
    input  logic [BLK_WID-1:0]           victim_data,
    output logic                         wb_req,
    output logic [INDEX_MSB-INDEX_LSB:0] wb_index,
    output logic [TAG_WID-1:0]           wb_tag,
    output logic [BLK_WID-1:0]           wb_data,
    input  logic                         wb_ack,
    output logic                         fill_req,
    output logic                         fill_excl,
    output logic [INDEX_MSB-INDEX_LSB:0] fill_index,
    output logic [TAG_WID-1:0]           fill_tag,
    input  logic                         fill_ack,
    input  logic [BLK_WID-1:0]           fill_data,
    input  logic                         fill_shared,
    output logic                         arr_wr_en,
    output logic [ASSOC_WID-1:0]         arr_wr_way,
    output logic [INDEX_MSB-INDEX_LSB:0] arr_wr_index,
    output logic [TAG_WID-1:0]           arr_wr_tag,
    output logic [1:0]                   arr_wr_state,
    output logic [BLK_WID-1:0]           arr_wr_data,
    output logic                         busy,
    output logic                         fill_done
);

    localparam int         IDX_WID = INDEX_MSB - INDEX_LSB + 1;
    localparam logic [1:0] MESI_S  = 2'b01;
    localparam logic [1:0] MESI_E  = 2'b10;
    localparam logic [1:0] MESI_M  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WID-1:0]   index_q;
    logic [TAG_WID-1:0]   tag_q;
    logic                 excl_q;
    logic [ASSOC_WID-1:0] way_q;
    logic [TAG_WID-1:0]   vtag_q;
    logic [BLK_WID-1:0]   vdata_q;
    logic [BLK_WID-1:0]   fdata_q;
    logic                 fshared_q;

    logic                 capture;
    logic                 fill_take;

    // The miss is only taken in IDLE. While busy, the captured values stay
    // frozen even if the upstream victim/LRU inputs move.
    assign capture   = (state_q == S_IDLE) && miss_req;
    assign fill_take = (state_q == S_FILL) && fill_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            tag_q     <= '0;
            excl_q    <= 1'b0;
            way_q     <= '0;
            vtag_q    <= '0;
            vdata_q   <= '0;
            fdata_q   <= '0;
            fshared_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                index_q <= miss_index;
                tag_q   <= miss_tag;
                excl_q  <= miss_excl;
                way_q   <= lru_replacement_proc;
                vtag_q  <= victim_tag;
                vdata_q <= victim_data;
            end
            if (fill_take) begin
                fdata_q   <= fill_data;
                fshared_q <= fill_shared;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wb_req       = 1'b0;
        wb_index     = '0;
        wb_tag       = '0;
        wb_data      = '0;
        fill_req     = 1'b0;
        fill_excl    = 1'b0;
        fill_index   = '0;
        fill_tag     = '0;
        arr_wr_en    = 1'b0;
        arr_wr_way   = '0;
        arr_wr_index = '0;
        arr_wr_tag   = '0;
        arr_wr_state = '0;
        arr_wr_data  = '0;
        busy         = 1'b0;
        fill_done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Only a Modified victim costs bus traffic; clean ones are
                // simply overwritten.
                if (miss_req) begin
                    state_d = (victim_state == MESI_M) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                busy     = 1'b1;
                wb_req   = 1'b1;
                wb_index = index_q;
                wb_tag   = vtag_q;
                wb_data  = vdata_q;
                if (wb_ack) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                busy       = 1'b1;
                fill_req   = 1'b1;
                fill_excl  = excl_q;
                fill_index = index_q;
                fill_tag   = tag_q;
                if (fill_ack) begin
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                busy         = 1'b1;
                arr_wr_en    = 1'b1;
                fill_done    = 1'b1;
                arr_wr_way   = way_q;
                arr_wr_index = index_q;
                arr_wr_tag   = tag_q;
                arr_wr_data  = fdata_q;
                // A write miss owns the line outright; otherwise the line is
                // Shared only if another cache reported holding a copy.
                if (excl_q) begin
                    arr_wr_state = MESI_M;
                end else if (fshared_q) begin
                    arr_wr_state = MESI_S;
                end else begin
                    arr_wr_state = MESI_E;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
